// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on CLK, decodes frames for
// PHY_ADDR and bridges reads/writes onto a simple user register port.
module mdio_phy_responder #(
   parameter logic [4:0] PHY_ADDR     = 5'd1,
   parameter int         PREAMBLE_LEN = 32,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MDC_IN,
   input  logic        MDIO_IN,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic [4:0]  REG_ADR,
   output logic        REG_RD,
   input  logic [15:0] REG_RD_DAT,
   output logic        REG_WR,
   output logic [15:0] REG_WR_DAT,
   output logic        BUSY
);

   typedef enum logic [3:0] {
      S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD,
      S_TA, S_RD_DATA, S_WR_DATA, S_SKIP
   } state_t;

   localparam logic [5:0] PLEN = 6'(PREAMBLE_LEN);

   logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
   logic mdc_prev_q;
   logic mdc_rise, bit_s;

   state_t      state_q, state_d;
   logic [5:0]  pcnt_q, pcnt_d;
   logic [4:0]  bcnt_q, bcnt_d;
   logic        op_hi_q, op_hi_d;
   logic        rd_q, rd_d;
   logic        inv_q, inv_d;
   logic [3:0]  phy_q, phy_d;
   logic [4:0]  adr_q, adr_d;
   logic [15:0] sh_q, sh_d;
   logic [15:0] wdat_q, wdat_d;
   logic        out_q, out_d;
   logic        oe_q, oe_d;
   logic        rdreq_q, rdreq_d;
   logic        wr_q, wr_d;
   logic        busy_q, busy_d;

   assign mdc_rise = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
   assign bit_s    = mdio_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      bcnt_d  = bcnt_q;
      op_hi_d = op_hi_q;
      rd_d    = rd_q;
      inv_d   = inv_q;
      phy_d   = phy_q;
      adr_d   = adr_q;
      sh_d    = sh_q;
      wdat_d  = wdat_q;
      out_d   = out_q;
      oe_d    = oe_q;
      rdreq_d = 1'b0;
      wr_d    = 1'b0;
      busy_d  = busy_q;
      // read data arrives the cycle after the request pulse
      if (rdreq_q) sh_d = REG_RD_DAT;
      if (mdc_rise) begin
         unique case (state_q)
            S_IDLE: begin
               if (bit_s) begin
                  pcnt_d = (pcnt_q == PLEN) ? PLEN : pcnt_q + 6'd1;
               end else if (pcnt_q == PLEN) begin
                  state_d = S_ST;
                  busy_d  = 1'b1;
                  pcnt_d  = 6'd0;
               end else begin
                  pcnt_d = 6'd0;
               end
            end
            S_ST: begin
               bcnt_d = 5'd0;
               if (bit_s) begin
                  state_d = S_OP;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  pcnt_d  = 6'd0;
               end
            end
            S_OP: begin
               if (bcnt_q == 5'd0) begin
                  op_hi_d = bit_s;
                  bcnt_d  = 5'd1;
               end else begin
                  rd_d    = op_hi_q & ~bit_s;
                  inv_d   = (op_hi_q == bit_s);
                  bcnt_d  = 5'd0;
                  state_d = S_PHYAD;
               end
            end
            S_PHYAD: begin
               phy_d = {phy_q[2:0], bit_s};
               if (bcnt_q == 5'd4) begin
                  bcnt_d = 5'd0;
                  if (inv_q || ({phy_q, bit_s} != PHY_ADDR)) state_d = S_SKIP;
                  else state_d = S_REGAD;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
            S_REGAD: begin
               adr_d = {adr_q[3:0], bit_s};
               if (bcnt_q == 5'd4) begin
                  bcnt_d  = 5'd0;
                  rdreq_d = rd_q;
                  state_d = S_TA;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
            S_TA: begin
               if (bcnt_q == 5'd0) begin
                  bcnt_d = 5'd1;
                  if (rd_q) begin
                     oe_d  = 1'b1;
                     out_d = 1'b0;
                  end
               end else begin
                  bcnt_d = 5'd0;
                  if (rd_q) begin
                     out_d   = sh_q[15];
                     sh_d    = {sh_q[14:0], 1'b0};
                     state_d = S_RD_DATA;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
            end
            S_RD_DATA: begin
               if (bcnt_q == 5'd15) begin
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  pcnt_d  = 6'd0;
                  bcnt_d  = 5'd0;
               end else begin
                  out_d  = sh_q[15];
                  sh_d   = {sh_q[14:0], 1'b0};
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
            S_WR_DATA: begin
               sh_d = {sh_q[14:0], bit_s};
               if (bcnt_q == 5'd15) begin
                  wdat_d  = {sh_q[14:0], bit_s};
                  wr_d    = 1'b1;
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  pcnt_d  = 6'd0;
                  bcnt_d  = 5'd0;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
            S_SKIP: begin
               if (bcnt_q == 5'd22) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  pcnt_d  = 6'd0;
                  bcnt_d  = 5'd0;
               end else begin
                  bcnt_d = bcnt_q + 5'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mdc_sync_q  <= '0;
         mdio_sync_q <= '0;
         mdc_prev_q  <= 1'b0;
         state_q     <= S_IDLE;
         pcnt_q      <= 6'd0;
         bcnt_q      <= 5'd0;
         op_hi_q     <= 1'b0;
         rd_q        <= 1'b0;
         inv_q       <= 1'b0;
         phy_q       <= 4'd0;
         adr_q       <= 5'd0;
         sh_q        <= 16'd0;
         wdat_q      <= 16'd0;
         out_q       <= 1'b0;
         oe_q        <= 1'b0;
         rdreq_q     <= 1'b0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], MDC_IN};
         mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], MDIO_IN};
         mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
         state_q     <= state_d;
         pcnt_q      <= pcnt_d;
         bcnt_q      <= bcnt_d;
         op_hi_q     <= op_hi_d;
         rd_q        <= rd_d;
         inv_q       <= inv_d;
         phy_q       <= phy_d;
         adr_q       <= adr_d;
         sh_q        <= sh_d;
         wdat_q      <= wdat_d;
         out_q       <= out_d;
         oe_q        <= oe_d;
         rdreq_q     <= rdreq_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
      end
   end

   assign MDIO_OUT   = out_q;
   assign MDIO_OE    = oe_q;
   assign REG_ADR    = adr_q;
   assign REG_RD     = rdreq_q;
   assign REG_WR     = wr_q;
   assign REG_WR_DAT = wdat_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: directed frame table, reset-abort sequence
// and random frames checked against a frame-level reference model.
module tb_mdio_phy_responder;

   localparam logic [4:0] PHY = 5'd1;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MDC_IN = 1'b0;
   logic        MDIO_IN = 1'b1;
   logic        MDIO_OUT, MDIO_OE, REG_RD, REG_WR, BUSY;
   logic [4:0]  REG_ADR;
   logic [15:0] REG_RD_DAT, REG_WR_DAT;

   logic [15:0] dut_mem [32];
   logic [15:0] mdl_mem [32];

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
   logic [4:0]  wr_adr, rd_adr;
   logic [15:0] wr_dat;

   logic cap_oe[$];
   logic cap_out[$];
   logic cap_busy[$];

   typedef struct {
      int          npre;
      logic [1:0]  st;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  rga;
      logic [15:0] dat;
      bit          exp_wr;
      bit          exp_rd;
   } vec_t;

   vec_t tbl[12];

   mdio_phy_responder #(
      .PHY_ADDR(PHY), .PREAMBLE_LEN(32), .SYNC_STAGES(2)
   ) dut (
      .CLK(CLK), .RST(RST), .MDC_IN(MDC_IN), .MDIO_IN(MDIO_IN),
      .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .REG_ADR(REG_ADR),
      .REG_RD(REG_RD), .REG_RD_DAT(REG_RD_DAT), .REG_WR(REG_WR),
      .REG_WR_DAT(REG_WR_DAT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   assign REG_RD_DAT = dut_mem[REG_ADR];

   // user register file behind the port, plus strobe bookkeeping
   always @(negedge CLK) begin
      if (REG_WR) begin
         wr_cnt = wr_cnt + 1;
         wr_adr = REG_ADR;
         wr_dat = REG_WR_DAT;
         dut_mem[REG_ADR] = REG_WR_DAT;
      end
      if (REG_RD) begin
         rd_cnt = rd_cnt + 1;
         rd_adr = REG_ADR;
      end
      if (REG_RD && REG_WR) both_cnt = both_cnt + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, bench did not finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // one MDC period of 8 CLK; pad seen by station sampled just before the rise
   task automatic send_bit(input logic b, input logic drv);
      @(negedge CLK);
      MDC_IN  = 1'b0;
      MDIO_IN = drv ? b : 1'b1;
      repeat (3) @(negedge CLK);
      @(negedge CLK);
      cap_oe.push_back(MDIO_OE);
      cap_out.push_back(MDIO_OE ? MDIO_OUT : 1'b1);
      cap_busy.push_back(BUSY);
      MDC_IN = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic send_header(input vec_t v);
      send_bit(1'b0, 1'b1);
      repeat (v.npre) send_bit(1'b1, 1'b1);
      for (int i = 1; i >= 0; i--) send_bit(v.st[i], 1'b1);
      for (int i = 1; i >= 0; i--) send_bit(v.op[i], 1'b1);
      for (int i = 4; i >= 0; i--) send_bit(v.phy[i], 1'b1);
      for (int i = 4; i >= 0; i--) send_bit(v.rga[i], 1'b1);
   endtask

   task automatic run_frame(input vec_t v, input string nm);
      int          w0, r0, base, noe;
      logic [15:0] exp_word, word;
      logic [1:0]  ta;
      bit          st_ok;
      logic        drv;
      w0 = wr_cnt;
      r0 = rd_cnt;
      exp_word = mdl_mem[v.rga];
      ta = 2'b10;
      drv = (v.op != 2'b10);
      st_ok = (v.npre >= 32) && (v.st == 2'b01);
      cap_oe.delete();
      cap_out.delete();
      cap_busy.delete();
      send_header(v);
      for (int i = 1; i >= 0; i--) send_bit(ta[i], drv);
      for (int i = 15; i >= 0; i--) send_bit(v.dat[i], drv);
      repeat (3) @(negedge CLK);
      base = 1 + v.npre + 14;
      noe = 0;
      foreach (cap_oe[i]) if (cap_oe[i]) noe++;
      for (int k = 0; k < 16; k++) word[15-k] = cap_out[base+2+k];
      check({nm, "/wr_cnt"}, wr_cnt - w0, {31'd0, v.exp_wr});
      check({nm, "/rd_cnt"}, rd_cnt - r0, {31'd0, v.exp_rd});
      check({nm, "/busy_ta"}, cap_busy[base], st_ok);
      check({nm, "/busy_end"}, BUSY, 1'b0);
      check({nm, "/oe_end"}, MDIO_OE, 1'b0);
      if (v.exp_wr) begin
         check({nm, "/wr_adr"}, wr_adr, v.rga);
         check({nm, "/wr_dat"}, wr_dat, v.dat);
         mdl_mem[v.rga] = v.dat;
      end
      if (v.exp_rd) begin
         check({nm, "/rd_adr"}, rd_adr, v.rga);
         check({nm, "/ta_oe"}, {cap_oe[base], cap_oe[base+1]}, 2'b01);
         check({nm, "/ta_zero"}, cap_out[base+1], 1'b0);
         check({nm, "/rd_word"}, word, exp_word);
         check({nm, "/oe_cycles"}, noe, 17);
      end else begin
         check({nm, "/no_drive"}, noe, 0);
      end
   endtask

   initial begin
      vec_t v;
      logic [15:0] r;
      bit ok;
      for (int i = 0; i < 32; i++) begin
         r = 16'($urandom);
         dut_mem[i] = r;
         mdl_mem[i] = r;
      end
      dut_mem[2] = 16'h796D;
      mdl_mem[2] = 16'h796D;

      tbl[0]  = '{32, 2'b01, 2'b01, 5'd1, 5'd3,  16'hA5C3, 1, 0};
      tbl[1]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  16'h0000, 0, 1};
      tbl[2]  = '{32, 2'b01, 2'b10, 5'd5, 5'd2,  16'h0000, 0, 0};
      tbl[3]  = '{31, 2'b01, 2'b01, 5'd1, 5'd7,  16'h1234, 0, 0};
      tbl[4]  = '{32, 2'b01, 2'b01, 5'd1, 5'd7,  16'h1234, 1, 0};
      tbl[5]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4,  16'h0001, 1, 0};
      tbl[6]  = '{32, 2'b01, 2'b11, 5'd1, 5'd4,  16'hFFFF, 0, 0};
      tbl[7]  = '{32, 2'b01, 2'b10, 5'd1, 5'd4,  16'h0000, 0, 1};
      tbl[8]  = '{32, 2'b00, 2'b01, 5'd1, 5'd9,  16'hBEEF, 0, 0};
      tbl[9]  = '{40, 2'b01, 2'b00, 5'd1, 5'd5,  16'h5555, 0, 0};
      tbl[10] = '{32, 2'b01, 2'b10, 5'd0, 5'd5,  16'h0000, 0, 0};
      tbl[11] = '{63, 2'b01, 2'b01, 5'd1, 5'd31, 16'hFFFF, 1, 0};

      repeat (3) @(negedge CLK);
      check("rst/oe", MDIO_OE, 1'b0);
      check("rst/out", MDIO_OUT, 1'b0);
      check("rst/rd", REG_RD, 1'b0);
      check("rst/wr", REG_WR, 1'b0);
      check("rst/adr", REG_ADR, 5'd0);
      check("rst/wdat", REG_WR_DAT, 16'd0);
      check("rst/busy", BUSY, 1'b0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 12; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

      // reset in the middle of a read data phase
      v = '{32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 0, 1};
      send_header(v);
      repeat (7) send_bit(1'b1, 1'b0);
      check("abort/oe_before", MDIO_OE, 1'b1);
      check("abort/busy_before", BUSY, 1'b1);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort/oe_after", MDIO_OE, 1'b0);
      check("abort/busy_after", BUSY, 1'b0);
      run_frame(v, "after_abort");

      for (int n = 0; n < 40; n++) begin
         v.npre = ($urandom_range(0, 5) == 0) ? 28 + int'($urandom_range(0, 3))
                                              : 32 + int'($urandom_range(0, 7));
         v.st   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
         v.op   = 2'($urandom);
         v.phy  = $urandom_range(0, 1) ? PHY : 5'($urandom);
         v.rga  = 5'($urandom);
         v.dat  = 16'($urandom);
         ok = (v.npre >= 32) && (v.st == 2'b01) && (v.phy == PHY);
         v.exp_wr = ok && (v.op == 2'b01);
         v.exp_rd = ok && (v.op == 2'b10);
         run_frame(v, $sformatf("rnd%0d", n));
      end

      check("never_both", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
